// File: rtl/varint_enc_fsm.sv
// LEB128 varint encoder: pops one word from a FWFT FIFO and emits
// 7-bit groups LSB first into a byte FIFO, optionally zigzag-mapped.
module varint_enc_fsm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ZIGZAG = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              varint_in_fifo_empty,
  output logic              varint_in_fifo_pop,
  output logic              varint_in_index_pop,
  input  logic [DATA_W-1:0] varint_in,
  input  logic              varint_out_fifo_full,
  output logic              varint_out_fifo_push,
  output logic [7:0]        varint_out,
  output logic              varint_out_index_push,
  output logic              varint_out_fifo_clr,
  output logic              varint_out_index_clr,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mapped;
  logic               more;

  generate
    if (ZIGZAG != 0) begin : g_zz
      assign mapped = {varint_in[DATA_W-2:0], 1'b0}
                    ^ {DATA_W{varint_in[DATA_W-1]}};
    end else begin : g_raw
      assign mapped = varint_in;
    end
  endgenerate

  // A continuation bit is set while any payload remains above this group.
  assign more     = |rem_q[DATA_W-1:7];
  assign done_cnt = cnt_q;

  always_comb begin
    state_d               = state_q;
    rem_d                 = rem_q;
    cnt_d                 = cnt_q;
    varint_in_fifo_pop    = 1'b0;
    varint_in_index_pop   = 1'b0;
    varint_out_fifo_push  = 1'b0;
    varint_out            = 8'h00;
    varint_out_index_push = 1'b0;
    varint_out_fifo_clr   = 1'b0;
    varint_out_index_clr  = 1'b0;
    busy                  = 1'b0;
    if (reset) begin
      state_d = IDLE;
      rem_d   = '0;
      cnt_d   = '0;
    end else if (clr) begin
      varint_out_fifo_clr  = 1'b1;
      varint_out_index_clr = 1'b1;
      busy                 = (state_q == EMIT);
      state_d              = IDLE;
      rem_d                = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!varint_in_fifo_empty) begin
            varint_in_fifo_pop  = 1'b1;
            varint_in_index_pop = 1'b1;
            rem_d               = mapped;
            state_d             = EMIT;
          end
        end
        EMIT: begin
          busy = 1'b1;
          if (!varint_out_fifo_full) begin
            varint_out_fifo_push = 1'b1;
            varint_out           = {more, rem_q[6:0]};
            rem_d                = rem_q >> 7;
            if (!more) begin
              varint_out_index_push = 1'b1;
              cnt_d                 = cnt_q + CNT_W'(1);
              state_d               = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_varint_enc_fsm.sv
// Bench for varint_enc_fsm: 32-bit, 64-bit and 32-bit zigzag instances
// driven from one vector table plus hand-written corner sequences.
module tb_varint_enc_fsm;

  logic        clk = 1'b0;
  logic        reset, clr, empty, full;
  logic [1:0]  sel;
  logic [31:0] din32;
  logic [63:0] din64;
  logic [2:0]  emp;
  logic [2:0]  pop, ipop, push, idx, fclr, iclr, bsy;
  logic [7:0]  outb [3];
  logic [15:0] dn   [3];
  int          nerr = 0;
  int          nchk = 0;
  int          edone [3];

  always #5 clk = ~clk;

  always_comb begin
    emp = 3'b111;
    emp[sel] = empty;
  end

  varint_enc_fsm #(.DATA_W(32), .ZIGZAG(0), .CNT_W(16)) u32 (
    .clk(clk), .reset(reset), .clr(clr),
    .varint_in_fifo_empty(emp[0]), .varint_in_fifo_pop(pop[0]),
    .varint_in_index_pop(ipop[0]), .varint_in(din32),
    .varint_out_fifo_full(full), .varint_out_fifo_push(push[0]),
    .varint_out(outb[0]), .varint_out_index_push(idx[0]),
    .varint_out_fifo_clr(fclr[0]), .varint_out_index_clr(iclr[0]),
    .busy(bsy[0]), .done_cnt(dn[0]));

  varint_enc_fsm #(.DATA_W(64), .ZIGZAG(0), .CNT_W(16)) u64 (
    .clk(clk), .reset(reset), .clr(clr),
    .varint_in_fifo_empty(emp[1]), .varint_in_fifo_pop(pop[1]),
    .varint_in_index_pop(ipop[1]), .varint_in(din64),
    .varint_out_fifo_full(full), .varint_out_fifo_push(push[1]),
    .varint_out(outb[1]), .varint_out_index_push(idx[1]),
    .varint_out_fifo_clr(fclr[1]), .varint_out_index_clr(iclr[1]),
    .busy(bsy[1]), .done_cnt(dn[1]));

  varint_enc_fsm #(.DATA_W(32), .ZIGZAG(1), .CNT_W(16)) uzz (
    .clk(clk), .reset(reset), .clr(clr),
    .varint_in_fifo_empty(emp[2]), .varint_in_fifo_pop(pop[2]),
    .varint_in_index_pop(ipop[2]), .varint_in(din32),
    .varint_out_fifo_full(full), .varint_out_fifo_push(push[2]),
    .varint_out(outb[2]), .varint_out_index_push(idx[2]),
    .varint_out_fifo_clr(fclr[2]), .varint_out_index_clr(iclr[2]),
    .busy(bsy[2]), .done_cnt(dn[2]));

  typedef struct packed {
    logic [1:0]  sel;
    logic [63:0] val;
    logic [3:0]  n;
    logic [79:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input logic [1:0] s, input logic [63:0] v,
                         input int n, input logic [79:0] e);
    @(negedge clk);
    sel = s; din32 = v[31:0]; din64 = v; empty = 1'b0;
    #1;
    chk("pop", {79'd0, pop[s]}, 80'd1);
    chk("idxpop", {79'd0, ipop[s]}, 80'd1);
    chk("nopush_at_pop", {79'd0, push[s]}, 80'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      chk("push", {79'd0, push[s]}, 80'd1);
      chk("byte", {72'd0, outb[s]}, {72'd0, e[k*8 +: 8]});
      chk("idxpush", {79'd0, idx[s]}, {79'd0, k == n - 1});
      chk("nopop_emit", {79'd0, pop[s]}, 80'd0);
      chk("busy", {79'd0, bsy[s]}, 80'd1);
    end
    edone[s]++;
    @(negedge clk);
    empty = 1'b1;
    #1;
    chk("idle_busy", {79'd0, bsy[s]}, 80'd0);
    chk("idle_push", {79'd0, push[s]}, 80'd0);
    chk("done_cnt", {64'd0, dn[s]}, 80'(edone[s]));
  endtask

  initial begin
    tbl[0] = '{2'd0, 64'd300,                 4'd2,  80'h02AC};
    tbl[1] = '{2'd0, 64'd0,                   4'd1,  80'h00};
    tbl[2] = '{2'd0, 64'hFFFF_FFFF,           4'd5,  80'h0F_FFFF_FFFF};
    tbl[3] = '{2'd0, 64'd127,                 4'd1,  80'h7F};
    tbl[4] = '{2'd0, 64'd128,                 4'd2,  80'h0180};
    tbl[5] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10,
               80'h01_FFFF_FFFF_FFFF_FFFF_FF};
    tbl[6] = '{2'd2, 64'hFFFF_FFFF,           4'd1,  80'h01};
    tbl[7] = '{2'd2, 64'd1,                   4'd1,  80'h02};
    tbl[8] = '{2'd2, 64'hFFFF_FFFE,           4'd1,  80'h03};
    for (int i = 0; i < 3; i++) edone[i] = 0;

    reset = 1'b1; clr = 1'b1; empty = 1'b0; full = 1'b0;
    sel = 2'd0; din32 = 32'd5; din64 = 64'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pop", {79'd0, pop[i]}, 80'd0);
      chk("rst_clr", {78'd0, fclr[i], iclr[i]}, 80'd0);
      chk("rst_push", {78'd0, push[i], idx[i]}, 80'd0);
      chk("rst_busy", {79'd0, bsy[i]}, 80'd0);
      chk("rst_out", {72'd0, outb[i]}, 80'd0);
      chk("rst_done", {64'd0, dn[i]}, 80'd0);
    end
    @(negedge clk);
    reset = 1'b0; clr = 1'b0; empty = 1'b1;

    foreach (tbl[i])
      run_vec(tbl[i].sel, tbl[i].val, int'(tbl[i].n), tbl[i].exp);

    // Backpressure before the first byte of 300.
    @(negedge clk);
    sel = 2'd0; din32 = 32'd300; empty = 1'b0;
    #1;
    chk("bp_pop", {79'd0, pop[0]}, 80'd1);
    @(negedge clk);
    empty = 1'b1; full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_nopush", {78'd0, push[0], idx[0]}, 80'd0);
      chk("bp_out", {72'd0, outb[0]}, 80'd0);
      chk("bp_busy", {79'd0, bsy[0]}, 80'd1);
      @(negedge clk);
    end
    full = 1'b0;
    #1;
    chk("bp_b0", {70'd0, push[0], idx[0], outb[0]}, {70'd0, 2'b10, 8'hAC});
    @(negedge clk);
    #1;
    chk("bp_b1", {70'd0, push[0], idx[0], outb[0]}, {70'd0, 2'b11, 8'h02});
    edone[0]++;
    @(negedge clk);
    #1;
    chk("bp_nodup", {79'd0, push[0]}, 80'd0);
    chk("bp_done", {64'd0, dn[0]}, 80'(edone[0]));

    // Abort 0xFFFFFFFF after two bytes.
    @(negedge clk);
    din32 = 32'hFFFF_FFFF; empty = 1'b0;
    #1;
    chk("clr_pop", {79'd0, pop[0]}, 80'd1);
    @(negedge clk);
    empty = 1'b1;
    #1;
    chk("clr_b0", {70'd0, push[0], idx[0], outb[0]}, {70'd0, 2'b10, 8'hFF});
    @(negedge clk);
    #1;
    chk("clr_b1", {70'd0, push[0], idx[0], outb[0]}, {70'd0, 2'b10, 8'hFF});
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_pulse", {78'd0, fclr[0], iclr[0]}, 80'd3);
    chk("clr_nopush", {78'd0, push[0], idx[0]}, 80'd0);
    chk("clr_out", {72'd0, outb[0]}, 80'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_end", {78'd0, fclr[0], iclr[0]}, 80'd0);
    chk("clr_stop", {78'd0, push[0], bsy[0]}, 80'd0);
    chk("clr_done", {64'd0, dn[0]}, 80'(edone[0]));
    @(negedge clk);
    din32 = 32'd300; empty = 1'b0; clr = 1'b1;
    #1;
    chk("clr_prio_pop", {79'd0, pop[0]}, 80'd0);
    chk("clr_prio_pulse", {79'd0, fclr[0]}, 80'd1);
    @(negedge clk);
    clr = 1'b0; empty = 1'b1;
    run_vec(2'd0, 64'd300, 2, 80'h02AC);

    // Reset in the middle of an emit.
    @(negedge clk);
    din32 = 32'hFFFF_FFFF; empty = 1'b0;
    #1;
    chk("rm_pop", {79'd0, pop[0]}, 80'd1);
    @(negedge clk);
    empty = 1'b1;
    #1;
    chk("rm_b0", {72'd0, outb[0]}, 80'hFF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rm_in_rst", {77'd0, push[0], bsy[0], idx[0]}, 80'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) edone[i] = 0;
    #1;
    chk("rm_after", {78'd0, push[0], bsy[0]}, 80'd0);
    chk("rm_done", {64'd0, dn[0]}, 80'd0);
    @(negedge clk);
    #1;
    chk("rm_quiet", {79'd0, push[0]}, 80'd0);
    run_vec(2'd0, 64'd127, 1, 80'h7F);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
